voice_allocator: RTL and testbench

- Polyphonic note scheduler between the Nios II note-event PIO path and a bank of NUM_VOICES NCO/ADSR voices.
- Accepts note-on/note-off events over a valid/ready handshake.
- Assigns each note-on to a voice by priority: retrigger same note, else free voice, else steal oldest.
- Drives each voice's note index (into the notes.mem frequency ROM) and its key_on gate.

---
 rtl/synth_pkg.sv | 26 ++
 rtl/voice_age_tracker.sv | 42 ++++
 rtl/voice_allocator.sv | 160 ++++++++++++++++
 tb/tb_voice_allocator.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and defaults for the polyphonic voice allocator.
package synth_pkg;

    localparam int NOTE_W_DEFAULT = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } alloc_state_t;

    typedef struct packed {
        logic                      on;
        logic [NOTE_W_DEFAULT-1:0] note;
    } note_event_t;

    // Outcome of the COMMIT cycle for the event in flight.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_RETRIG,
        ACT_LOAD,
        ACT_RELEASE,
        ACT_DROP
    } commit_act_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Least-recently-allocated tracker: ages form a permutation of 0..NUM_VOICES-1,
// the allocated voice becomes youngest and the voice at the top age is the oldest.
module voice_age_tracker #(
    parameter int NUM_VOICES = 4
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          alloc_i,
    input  logic [$clog2(NUM_VOICES)-1:0] alloc_idx_i,
    output logic [$clog2(NUM_VOICES)-1:0] oldest_o
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    logic [IDX_W-1:0] age_q [NUM_VOICES];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                age_q[i] <= IDX_W'(i);
            end
        end else if (alloc_i) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == alloc_idx_i) begin
                    age_q[i] <= '0;
                end else if (age_q[i] < age_q[alloc_idx_i]) begin
                    age_q[i] <= age_q[i] + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        oldest_o = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (age_q[i] == IDX_W'(NUM_VOICES - 1)) begin
                oldest_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Note-event scheduler for the NCO/ADSR voice bank: retrigger, else free voice, else
// (with VOICE_STEAL_EN defined) steal the oldest voice; otherwise the event is dropped.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = NOTE_W_DEFAULT
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_on,
    input  logic [NOTE_W-1:0]            ev_note,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_key_on,
    output logic [NUM_VOICES-1:0]        voice_load,
    output logic                         ev_dropped
);

    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    alloc_state_t          state_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  ev_on_q;
    logic [NOTE_W-1:0]     ev_note_q;
    logic                  match_found_q, free_found_q;
    logic [IDX_W-1:0]      match_idx_q, free_idx_q;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] key_on_q, load_q;
    logic                  ready_q, dropped_q;

    commit_act_t           act;
    logic [IDX_W-1:0]      tgt;
    logic                  alloc;

`ifdef VOICE_STEAL_EN
    logic [IDX_W-1:0]      oldest_idx;

    voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_age (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .alloc_i    (alloc),
        .alloc_idx_i(tgt),
        .oldest_o   (oldest_idx)
    );
`endif

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        act = ACT_NONE;
        tgt = '0;
        if (state_q == COMMIT) begin
            if (ev_on_q) begin
                if (match_found_q) begin
                    act = ACT_RETRIG;
                    tgt = match_idx_q;
                end else if (free_found_q) begin
                    act = ACT_LOAD;
                    tgt = free_idx_q;
                end else begin
`ifdef VOICE_STEAL_EN
                    act = ACT_LOAD;
                    tgt = oldest_idx;
`else
                    act = ACT_DROP;
`endif
                end
            end else if (match_found_q) begin
                act = ACT_RELEASE;
                tgt = match_idx_q;
            end else begin
                act = ACT_DROP;
            end
        end
    end

    assign alloc = (act == ACT_RETRIG) || (act == ACT_LOAD);

    // NOTE: the per-voice note registers are reset too, because voice_note must read zero out of reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            ev_on_q       <= 1'b0;
            ev_note_q     <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
            match_idx_q   <= '0;
            free_idx_q    <= '0;
            key_on_q      <= '0;
            load_q        <= '0;
            ready_q       <= 1'b0;
            dropped_q     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking defaults make the pulses one cycle wide; a later assignment in the same edge wins.
            load_q    <= '0;
            dropped_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (ev_valid && ready_q) begin
                        ev_on_q       <= ev_on;
                        ev_note_q     <= ev_note;
                        match_found_q <= 1'b0;
                        free_found_q  <= 1'b0;
                        match_idx_q   <= '0;
                        free_idx_q    <= '0;
                        idx_q         <= '0;
                        ready_q       <= 1'b0;
                        state_q       <= SCAN;
                    end
                end
                SCAN: begin
                    if (!match_found_q && key_on_q[idx_q] && (note_q[idx_q] == ev_note_q)) begin
                        match_found_q <= 1'b1;
                        match_idx_q   <= idx_q;
                    end
                    if (!free_found_q && !key_on_q[idx_q]) begin
                        free_found_q <= 1'b1;
                        free_idx_q   <= idx_q;
                    end
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    unique case (act)
                        ACT_RETRIG: load_q[tgt] <= 1'b1;
                        ACT_LOAD: begin
                            note_q[tgt]   <= ev_note_q;
                            key_on_q[tgt] <= 1'b1;
                            load_q[tgt]   <= 1'b1;
                        end
                        ACT_RELEASE: key_on_q[tgt] <= 1'b0;
                        ACT_DROP:    dropped_q     <= 1'b1;
                        default: ;
                    endcase
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_pack
        assign voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
    end

    assign ev_ready     = ready_q;
    assign voice_key_on = key_on_q;
    assign voice_load   = load_q;
    assign ev_dropped   = dropped_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: reference model of voices/ages/handshake timing,
// directed scenarios with literal expectations, then randomized events. Honors VOICE_STEAL_EN.
module tb_voice_allocator;
    import synth_pkg::*;

    localparam int NV = 4;
    localparam int NW = NOTE_W_DEFAULT;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             ev_valid = 1'b0;
    logic             ev_on    = 1'b0;
    logic [NW-1:0]    ev_note  = '0;
    logic             ev_ready;
    logic [NV*NW-1:0] voice_note;
    logic [NV-1:0]    voice_key_on;
    logic [NV-1:0]    voice_load;
    logic             ev_dropped;

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW)) dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_on       (ev_on),
        .ev_note     (ev_note),
        .voice_note  (voice_note),
        .voice_key_on(voice_key_on),
        .voice_load  (voice_load),
        .ev_dropped  (ev_dropped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NW-1:0] m_note [NV];
    bit            m_key  [NV];
    int            m_age  [NV];
    logic [NV-1:0] m_load;
    bit            m_drop, m_ready, m_busy;
    int            m_cnt;
    note_event_t   m_ev;

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = '0;
            m_key[i]  = 1'b0;
            m_age[i]  = i;
        end
        m_load  = '0;
        m_drop  = 1'b0;
        m_ready = 1'b0;
        m_busy  = 1'b0;
        m_cnt   = 0;
    endfunction

    function automatic void model_alloc(input int v);
        int a = m_age[v];
        for (int i = 0; i < NV; i++) if (m_age[i] < a) m_age[i]++;
        m_age[v] = 0;
    endfunction

    function automatic void model_apply(input note_event_t e);
        int hit  = -1;
        int free = -1;
        for (int i = 0; i < NV; i++) begin
            if (hit < 0 && m_key[i] && m_note[i] == e.note) hit = i;
            if (free < 0 && !m_key[i]) free = i;
        end
        if (e.on) begin
            if (hit >= 0) begin
                m_load[hit] = 1'b1;
                model_alloc(hit);
            end else if (free >= 0) begin
                m_note[free] = e.note;
                m_key[free]  = 1'b1;
                m_load[free] = 1'b1;
                model_alloc(free);
            end else begin
`ifdef VOICE_STEAL_EN
                int oldest = 0;
                for (int i = 0; i < NV; i++) if (m_age[i] == NV - 1) oldest = i;
                m_note[oldest] = e.note;
                m_load[oldest] = 1'b1;
                model_alloc(oldest);
`else
                m_drop = 1'b1;
`endif
            end
        end else if (hit >= 0) begin
            m_key[hit] = 1'b0;
        end else begin
            m_drop = 1'b1;
        end
    endfunction

    // Event takes effect NV+1 edges after acceptance, ready returns one edge later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_load = '0;
            m_drop = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == NV + 1) model_apply(m_ev);
                else if (m_cnt == NV + 2) begin
                    m_busy  = 1'b0;
                    m_ready = 1'b1;
                end
            end else if (!m_ready) begin
                m_ready = 1'b1;
            end else if (ev_valid) begin
                m_ev.on   = ev_on;
                m_ev.note = ev_note;
                m_busy    = 1'b1;
                m_cnt     = 0;
                m_ready   = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;
    int pulses = 0;

    always @(negedge clk) begin
        logic [NV*NW-1:0] exp_vn;
        logic [NV-1:0]    exp_key;
        if (voice_load != '0 || ev_dropped) pulses++;
        if (cmp_en) begin
            for (int i = 0; i < NV; i++) begin
                exp_vn[i*NW +: NW] = m_note[i];
                exp_key[i]         = m_key[i];
            end
            check("cyc_ev_ready", ev_ready, m_ready);
            check("cyc_voice_note", voice_note, exp_vn);
            check("cyc_key_on", voice_key_on, exp_key);
            check("cyc_voice_load", voice_load, m_load);
            check("cyc_ev_dropped", ev_dropped, m_drop);
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [NW-1:0] note_of(input int v);
        return voice_note[v*NW +: NW];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        ev_valid = 1'b0;
        @(negedge clk);
        check("rst_key_on", voice_key_on, 0);
        check("rst_ready", ev_ready, 0);
        check("rst_note", voice_note, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", ev_ready, 1);
    endtask

    task automatic send(input bit on, input logic [NW-1:0] note);
        int t = 0;
        @(negedge clk);
        ev_on    = on;
        ev_note  = note;
        ev_valid = 1'b1;
        while (!ev_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", t < 100, 1);
        @(posedge clk);
        #1 ev_valid = 1'b0;
    endtask

    task automatic finish_ev(output int low, output logic [NV-1:0] ld, output int ld_cnt, output int dr_cnt);
        low    = 0;
        ld     = '0;
        ld_cnt = 0;
        dr_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (voice_load != '0) begin
                ld = voice_load;
                ld_cnt++;
            end
            if (ev_dropped) dr_cnt++;
            if (ev_ready) break;
            low++;
        end
        check("idle_timeout", ev_ready, 1);
    endtask

    task automatic on_off(input bit on, input logic [NW-1:0] note);
        int low, lc, dc;
        logic [NV-1:0] ld;
        send(on, note);
        finish_ev(low, ld, lc, dc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int low, lc, dc, p0;
        logic [NV-1:0] ld;
        logic [NV*NW-1:0] exp_pack;

        model_reset();
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        check("init_ready", ev_ready, 0);
        check("init_load", voice_load, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_ready", ev_ready, 1);

        // Scenario A: first note, fill, then the no-free-voice case
        send(1'b1, 7'd60);
        finish_ev(low, ld, lc, dc);
        check("busy_cycles", low, NV + 2);
        check("on60_note0", note_of(0), 60);
        check("on60_key", voice_key_on, 4'b0001);
        check("on60_load", ld, 4'b0001);
        check("on60_load_cycles", lc, 1);
        on_off(1'b1, 7'd62);
        on_off(1'b1, 7'd64);
        on_off(1'b1, 7'd65);
        check("fill_key", voice_key_on, 4'b1111);
        exp_pack = {7'd65, 7'd64, 7'd62, 7'd60};
        check("fill_notes", voice_note, exp_pack);
        send(1'b1, 7'd67);
        finish_ev(low, ld, lc, dc);
`ifdef VOICE_STEAL_EN
        check("steal67_note0", note_of(0), 67);
        check("steal67_load", ld, 4'b0001);
        check("steal67_drop", dc, 0);
        send(1'b1, 7'd69);
        finish_ev(low, ld, lc, dc);
        check("steal69_note1", note_of(1), 69);
        check("steal69_load", ld, 4'b0010);
        check("steal69_key", voice_key_on, 4'b1111);
`else
        check("nosteal_drop", dc, 1);
        check("nosteal_load", lc, 0);
        check("nosteal_notes", voice_note, exp_pack);
`endif

        // Scenario B: retrigger, release, reuse, unmatched note-off, held valid
        do_reset();
        on_off(1'b1, 7'd60);
        on_off(1'b1, 7'd62);
        on_off(1'b1, 7'd64);
        on_off(1'b1, 7'd65);
        send(1'b1, 7'd60);
        finish_ev(low, ld, lc, dc);
        check("retrig_load", ld, 4'b0001);
        check("retrig_load_cycles", lc, 1);
        check("retrig_key", voice_key_on, 4'b1111);
        check("retrig_notes", voice_note, exp_pack);
        send(1'b0, 7'd62);
        finish_ev(low, ld, lc, dc);
        check("off62_key", voice_key_on, 4'b1101);
        check("off62_note1", note_of(1), 62);
        check("off62_noload", lc, 0);
        send(1'b1, 7'd70);
        finish_ev(low, ld, lc, dc);
        check("on70_note1", note_of(1), 70);
        check("on70_load", ld, 4'b0010);
        send(1'b0, 7'd99);
        finish_ev(low, ld, lc, dc);
        check("off99_drop", dc, 1);
        check("off99_noload", lc, 0);
        exp_pack = {7'd65, 7'd64, 7'd70, 7'd60};
        check("off99_notes", voice_note, exp_pack);
        check("off99_key", voice_key_on, 4'b1111);
        p0 = pulses;
        send(1'b1, 7'd72);
        send(1'b0, 7'd99);
        finish_ev(low, ld, lc, dc);
        repeat (8) @(negedge clk);
        check("held_valid_once", pulses - p0, 2);
        check("held_idle_ready", ev_ready, 1);

        // Scenario C: reset while an event is being scanned
        do_reset();
        on_off(1'b1, 7'd50);
        send(1'b1, 7'd60);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midscan_note", voice_note, 0);
        check("midscan_key", voice_key_on, 0);
        check("midscan_ready", ev_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b1, 7'd60);
        finish_ev(low, ld, lc, dc);
        check("after_rst_note0", note_of(0), 60);
        check("after_rst_key", voice_key_on, 4'b0001);
        check("after_rst_load", ld, 4'b0001);

        // Randomized events; the compare process checks every cycle
        do_reset();
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send($urandom_range(0, 2) != 0, NW'(40 + $urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) begin
                finish_ev(low, ld, lc, dc);
            end
        end
        finish_ev(low, ld, lc, dc);
        repeat (4) @(negedge clk);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
